// File: rtl/seg7_scan_display_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan driver.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a.
package seg7_scan_display_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;

  typedef logic [1:0] slot_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_out_t;

  localparam disp_out_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF, dp: 1'b1};

  // Active-low one-hot anode strobe for a slot.
  function automatic logic [3:0] an_strobe(input slot_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display bundle: BCD digits and display options in, strobed anode/segment lines out.
interface seg7_scan_display_if;

  logic [15:0] digits;
  logic        blank_lz;
  logic        blink_en;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output digits, blank_lz, blink_en, dp_mask,
    input  an, seg, dp
  );

  modport slave (
    input  digits, blank_lz, blink_en, dp_mask,
    output an, seg, dp
  );

endinterface

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module seg7_scan_display_bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for a 4-digit common-anode display with leading-zero
// blanking, whole-display blink and per-digit decimal point.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLINK_DIV   = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_display_if.slave bus
);

  localparam int unsigned RefW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RefW-1:0]   RefLast   = RefW'(REFRESH_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [RefW-1:0]   r_refresh_cnt;
  slot_t             r_idx;
  logic [BlinkW-1:0] r_blink_cnt;
  logic              r_blink_phase;
  disp_out_t         r_out;

  logic [3:0] w_nibble;
  logic [6:0] w_seg;
  logic [3:0] w_zero_from;
  logic       w_blank;
  logic       w_dark;
  disp_out_t  w_next;

  seg7_scan_display_bcd_to_seg7 u_dec (
    .i_bcd (w_nibble),
    .o_seg (w_seg)
  );

  always_comb begin
    w_nibble = bus.digits[{r_idx, 2'b00} +: 4];

    // w_zero_from[i]: nibble i and every nibble above it are zero.
    w_zero_from[3] = (bus.digits[15:12] == 4'd0);
    w_zero_from[2] = w_zero_from[3] && (bus.digits[11:8] == 4'd0);
    w_zero_from[1] = w_zero_from[2] && (bus.digits[7:4] == 4'd0);
    w_zero_from[0] = w_zero_from[1] && (bus.digits[3:0] == 4'd0);

    w_blank = bus.blank_lz && (r_idx != 2'd0) && w_zero_from[r_idx];
    w_dark  = bus.blink_en && !r_blink_phase;

    w_next = DISP_OFF;
    if (!w_blank && !w_dark) begin
      w_next.an  = an_strobe(r_idx);
      w_next.seg = w_seg;
      w_next.dp  = ~bus.dp_mask[r_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_idx         <= 2'd0;
    end else if (r_refresh_cnt == RefLast) begin
      r_refresh_cnt <= '0;
      r_idx         <= r_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + RefW'(1);
    end
  end

  // Holding the phase visible while disabled gives a full lit half-period on enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (!bus.blink_en) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (r_blink_cnt == BlinkLast) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BlinkW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= DISP_OFF;
    end else begin
      r_out <= w_next;
    end
  end

  assign bus.an  = r_out.an;
  assign bus.seg = r_out.seg;
  assign bus.dp  = r_out.dp;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with REFRESH_DIV=4, BLINK_DIV=16.
module tb_seg7_scan_display;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg7_scan_display_if dut_if ();

  seg7_scan_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int slot  = 0;

  // Expected lit pattern per slot for the current stimulus.
  logic [3:0] e_an  [4];
  logic [6:0] e_seg [4];
  logic       e_dp  [4];

  task automatic check(input string tag, input logic [3:0] an, input logic [6:0] seg,
                       input logic dp);
    total++;
    assert (dut_if.an === an && dut_if.seg === seg && dut_if.dp === dp) else begin
      bad++;
      $error("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
             tag, cyc, dut_if.an, dut_if.seg, dut_if.dp, an, seg, dp);
    end
  endtask

  task automatic set_slot(input int s, input logic [3:0] an, input logic [6:0] seg,
                          input logic dp);
    e_an[s]  = an;
    e_seg[s] = seg;
    e_dp[s]  = dp;
  endtask

  // One clock; each slot stays lit for 4 edges after reset release.
  task automatic tick_check(input string tag, input bit dark);
    @(negedge clk);
    cyc++;
    slot = ((cyc - 1) / 4) % 4;
    if (dark) check(tag, 4'b1111, 7'b1111111, 1'b1);
    else      check(tag, e_an[slot], e_seg[slot], e_dp[slot]);
  endtask

  task automatic load_1234(input logic [3:0] dpm);
    set_slot(0, 4'b1110, 7'b0011001, ~dpm[0]);
    set_slot(1, 4'b1101, 7'b0110000, ~dpm[1]);
    set_slot(2, 4'b1011, 7'b0100100, ~dpm[2]);
    set_slot(3, 4'b0111, 7'b1111001, ~dpm[3]);
  endtask

  initial begin
    rst             = 1'b1;
    dut_if.digits   = 16'h1234;
    dut_if.blank_lz = 1'b0;
    dut_if.blink_en = 1'b0;
    dut_if.dp_mask  = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset", 4'b1111, 7'b1111111, 1'b1);

    // Plain scan of 1234, including wrap back to slot 0
    load_1234(4'b0000);
    rst = 1'b0;
    cyc = 0;
    repeat (20) tick_check("scan1234", 1'b0);

    // Leading-zero blanking
    dut_if.digits   = 16'h0050;
    dut_if.blank_lz = 1'b1;
    set_slot(0, 4'b1110, 7'b1000000, 1'b1);
    set_slot(1, 4'b1101, 7'b0010010, 1'b1);
    set_slot(2, 4'b1111, 7'b1111111, 1'b1);
    set_slot(3, 4'b1111, 7'b1111111, 1'b1);
    repeat (16) tick_check("lz0050", 1'b0);

    dut_if.digits = 16'h0000;
    set_slot(1, 4'b1111, 7'b1111111, 1'b1);
    repeat (16) tick_check("lz0000", 1'b0);

    // Non-BCD nibble is a dash and counts as nonzero
    dut_if.digits = 16'h00A9;
    set_slot(0, 4'b1110, 7'b0010000, 1'b1);
    set_slot(1, 4'b1101, 7'b0111111, 1'b1);
    repeat (16) tick_check("dash00A9", 1'b0);

    // Blink: 16 lit, 16 dark, 16 lit, then drop enable while dark
    dut_if.digits   = 16'h1234;
    dut_if.blank_lz = 1'b0;
    dut_if.blink_en = 1'b1;
    load_1234(4'b0000);
    repeat (16) tick_check("blink_lit1", 1'b0);
    repeat (16) tick_check("blink_dark1", 1'b1);
    repeat (16) tick_check("blink_lit2", 1'b0);
    repeat (4)  tick_check("blink_dark2", 1'b1);
    dut_if.blink_en = 1'b0;
    repeat (8)  tick_check("blink_off", 1'b0);

    // Decimal point on slot 2 only
    dut_if.dp_mask = 4'b0100;
    load_1234(4'b0100);
    repeat (16) tick_check("dp", 1'b0);
    for (int i = 0; i < 16 && slot != 2; i++) tick_check("dp_seek", 1'b0);
    check("dp_slot2", 4'b1011, 7'b0100100, 1'b0);

    // Asynchronous reset in the middle of slot 2
    #2 rst = 1'b1;
    #1 check("rst_async", 4'b1111, 7'b1111111, 1'b1);
    @(negedge clk);
    check("rst_hold", 4'b1111, 7'b1111111, 1'b1);
    rst = 1'b0;
    cyc = 0;
    repeat (8) tick_check("restart", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
